// File: rtl/uart_inst_rx_if.sv
// Bus between a host-side UART byte source / sequencer and the
// uart_inst_rx instruction parser. The master modport is the
// environment (UART RX, TX busy, sequencer). The slave modport is
// the parser block.
interface uart_inst_rx_if #(
  parameter int FIFO_AW = 3,
  parameter int INST_W  = 8
);

  // UART receive side and TX back-pressure
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              i_tx_busy;

  // Instruction issue to the sequencer, plus status
  logic [INST_W-1:0] o_inst;
  logic              o_inst_valid;
  logic              o_parse_err;
  logic              o_ovf;
  logic [FIFO_AW:0]  o_level;

  modport master (
    output i_rx_data,
    output i_rx_valid,
    output i_tx_busy,
    input  o_inst,
    input  o_inst_valid,
    input  o_parse_err,
    input  o_ovf,
    input  o_level
  );

  modport slave (
    input  i_rx_data,
    input  i_rx_valid,
    input  i_tx_busy,
    output o_inst,
    output o_inst_valid,
    output o_parse_err,
    output o_ovf,
    output o_level
  );

endinterface

// File: rtl/uart_inst_rx.sv
// UART-side instruction source.
// ASCII hex pairs arriving from the UART receiver are assembled into
// bytes and queued in a small FIFO. Each byte is then issued to the
// sequencer as a one-cycle strobe. Issues are spaced at least
// ISSUE_GAP idle cycles apart, and they are held off while the UART
// TX is busy, so that the replies from the sequencer are not overrun.
module uart_inst_rx #(
  parameter int FIFO_AW   = 3,
  parameter int ISSUE_GAP = 16,
  parameter int INST_W    = 8
) (
  input logic          clk,
  input logic          rst,
  uart_inst_rx_if.slave bus
);

  localparam int               DEPTH_I = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW + 1)'(DEPTH_I);
  localparam logic [7:0]       GAP_LD  = 8'(ISSUE_GAP);

  typedef enum logic {
    P_IDLE,
    P_HI
  } pstate_t;

  // ---------------------------------------------------------------
  // Character classification
  // ---------------------------------------------------------------
  logic       is_hex;
  logic       is_ws;
  logic [3:0] nib;

  // Decode the incoming ASCII byte into HEX / WS / BAD and a nibble value
  always_comb begin
    is_hex = 1'b0;
    is_ws  = 1'b0;
    nib    = '0;
    case (bus.i_rx_data) inside
      [8'h30:8'h39]: begin
        is_hex = 1'b1;
        nib    = bus.i_rx_data[3:0];
      end
      [8'h41:8'h46], [8'h61:8'h66]: begin
        is_hex = 1'b1;
        nib    = bus.i_rx_data[3:0] + 4'd9;
      end
      8'h20, 8'h0D, 8'h0A: begin
        is_ws = 1'b1;
      end
      default: begin
        is_hex = 1'b0;
        is_ws  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Parser FSM
  // ---------------------------------------------------------------
  pstate_t    pstate;
  pstate_t    pstate_nxt;
  logic [3:0] hi_nib;
  logic [3:0] hi_nib_nxt;
  logic       push_req;
  logic [7:0] push_byte;
  logic       err_nxt;
  logic       parse_err_r;

  // Parser state and held high nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      pstate <= P_IDLE;
      hi_nib <= '0;
    end else begin
      pstate <= pstate_nxt;
      hi_nib <= hi_nib_nxt;
    end
  end

  // Parser next state, push request and error detection
  always_comb begin
    pstate_nxt = pstate;
    hi_nib_nxt = hi_nib;
    push_req   = 1'b0;
    push_byte  = {hi_nib, nib};
    err_nxt    = 1'b0;
    if (bus.i_rx_valid) begin
      unique case (pstate)
        P_IDLE: begin
          if (is_hex) begin
            hi_nib_nxt = nib;
            pstate_nxt = P_HI;
          end else if (!is_ws) begin
            err_nxt = 1'b1;
          end
        end
        P_HI: begin
          // Any non-hex character here abandons the half-built byte
          if (is_hex) begin
            push_req = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          hi_nib_nxt = '0;
          pstate_nxt = P_IDLE;
        end
        default: begin
          pstate_nxt = P_IDLE;
        end
      endcase
    end
  end

  // Error pulse is registered and appears the cycle after the bad strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      parse_err_r <= 1'b0;
    end else begin
      parse_err_r <= err_nxt;
    end
  end

  // ---------------------------------------------------------------
  // FIFO and issue control
  // ---------------------------------------------------------------
  logic [7:0]        mem [DEPTH_I];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]  count;
  logic              full;
  logic              pop;
  logic              do_push;
  logic              drop;
  logic [7:0]        gap;
  logic [INST_W-1:0] inst_r;
  logic              inst_valid_r;
  logic              ovf_r;

  // Issue and push decisions for this cycle.
  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // accepted when an issue happens in that cycle.
  always_comb begin
    full    = (count == DEPTH);
    pop     = (count != '0) && (gap == '0) && !bus.i_tx_busy && !inst_valid_r;
    do_push = push_req && (!full || pop);
    drop    = push_req && full && !pop;
  end

  // FIFO storage; the pointers gate validity, so no reset is needed here
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Issue register: the popped head drives the sequencer for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_r       <= '0;
      inst_valid_r <= 1'b0;
    end else begin
      inst_valid_r <= pop;
      if (pop) begin
        inst_r <= mem[rd_ptr][INST_W-1:0];
      end
    end
  end

  // Pacing counter: reloaded on issue, counts down to zero otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      gap <= '0;
    end else if (pop) begin
      gap <= GAP_LD;
    end else if (gap != '0) begin
      gap <= gap - 1'b1;
    end
  end

  assign bus.o_inst       = inst_r;
  assign bus.o_inst_valid = inst_valid_r;
  assign bus.o_parse_err  = parse_err_r;
  assign bus.o_ovf        = ovf_r;
  assign bus.o_level      = count;

endmodule

// File: tb/tb_uart_inst_rx.sv
// Bench for uart_inst_rx. Stimulus sends ASCII characters. Each
// expected instruction byte is pushed to a scoreboard queue when its
// pair is sent. A negedge monitor pops the queue and compares on every
// issue strobe. The scenario tasks also check timing, level and flags.
module tb_uart_inst_rx;

  localparam int FIFO_AW   = 3;
  localparam int ISSUE_GAP = 16;
  localparam int INST_W    = 8;

  logic clk;
  logic rst;

  uart_inst_rx_if #(.FIFO_AW(FIFO_AW), .INST_W(INST_W)) bus ();

  uart_inst_rx #(
    .FIFO_AW  (FIFO_AW),
    .ISSUE_GAP(ISSUE_GAP),
    .INST_W   (INST_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         issue_cyc_q[$];
  int         issue_cnt = 0;
  int         err_cnt   = 0;
  int         cyc       = 0;
  logic       prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every issue strobe must match the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_inst_valid) begin
        n_vec++;
        issue_cnt++;
        issue_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL issue_unexpected: o_inst=%02h issued, none expected", bus.o_inst);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.o_inst !== e[INST_W-1:0]) begin
            n_err++;
            $display("FAIL issue_data: o_inst=%02h expected %02h", bus.o_inst, e);
          end
        end
        if (prev_valid) begin
          n_err++;
          $display("FAIL valid_width: o_inst_valid high two cycles in a row");
        end
      end
      if (bus.o_parse_err === 1'b1) err_cnt++;
      prev_valid = bus.o_inst_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  task automatic send_char(input logic [7:0] c);
    bus.i_rx_data  = c;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] b, input bit lower, input bit expect_push);
    if (expect_push) exp_q.push_back(b);
    send_char(hex_char(b[7:4], lower));
    send_char(hex_char(b[3:0], lower));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_rx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input int limit, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.o_inst_valid) && k < limit) begin
      tick();
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d bytes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_spacing(input int first, input int n, input string name);
    for (int i = first + 1; i < first + n && i < issue_cyc_q.size(); i++) begin
      n_vec++;
      if (issue_cyc_q[i] - issue_cyc_q[i-1] !== ISSUE_GAP + 1) begin
        n_err++;
        $display("FAIL %s_spacing: gap %0d cycles, required %0d",
                 name, issue_cyc_q[i] - issue_cyc_q[i-1], ISSUE_GAP + 1);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({bus.o_inst, bus.o_inst_valid, bus.o_parse_err, bus.o_ovf, bus.o_level} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: inst=%02h v=%b err=%b ovf=%b lvl=%0d, required all 0",
               bus.o_inst, bus.o_inst_valid, bus.o_parse_err, bus.o_ovf, bus.o_level);
    end
    tick();
  endtask

  task automatic test_single();
    int e0;
    e0 = err_cnt;
    send_pair(8'h3A, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (bus.o_inst_valid !== 1'b0 || bus.o_level !== 4'd1) begin
      n_err++;
      $display("FAIL single_t1: v=%b lvl=%0d, required v=0 lvl=1", bus.o_inst_valid, bus.o_level);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== 8'h3A || bus.o_level !== 4'd0) begin
      n_err++;
      $display("FAIL single_t2: v=%b inst=%02h lvl=%0d, required v=1 inst=3a lvl=0",
               bus.o_inst_valid, bus.o_inst, bus.o_level);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (bus.o_inst_valid !== 1'b0 || bus.o_inst !== 8'h3A) begin
      n_err++;
      $display("FAIL single_hold: v=%b inst=%02h, required v=0 inst=3a", bus.o_inst_valid, bus.o_inst);
    end
    n_vec++;
    if (err_cnt != e0) begin
      n_err++;
      $display("FAIL single_err: %0d parse errors, required 0", err_cnt - e0);
    end
    tick();
  endtask

  task automatic test_whitespace();
    int e0, i0;
    logic [7:0] s [7];
    s = '{8'h66, 8'h46, 8'h20, 8'h30, 8'h61, 8'h0D, 8'h0A};
    e0 = err_cnt;
    i0 = issue_cyc_q.size();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h0A);
    for (int i = 0; i < 7; i++) send_char(s[i]);
    wait_drain(100, "ws");
    check_spacing(i0, 2, "ws");
    n_vec++;
    if (err_cnt != e0) begin
      n_err++;
      $display("FAIL ws_err: %0d parse errors, required 0", err_cnt - e0);
    end
  endtask

  task automatic test_parse_err();
    int e0, c0;
    e0 = err_cnt;
    send_char(8'h47);
    @(negedge clk);
    n_vec++;
    if (bus.o_parse_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_bad_char: o_parse_err=%b, required 1", bus.o_parse_err);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (bus.o_parse_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_pulse_width: o_parse_err=%b, required 0", bus.o_parse_err);
    end
    tick();
    c0 = issue_cnt;
    send_char(8'h33);
    send_char(8'h20);
    @(negedge clk);
    n_vec++;
    if (bus.o_parse_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_ws_in_hi: o_parse_err=%b, required 1", bus.o_parse_err);
    end
    tick();
    send_char(8'h34);
    repeat (6) tick();
    n_vec++;
    if (err_cnt - e0 != 2 || issue_cnt != c0) begin
      n_err++;
      $display("FAIL err_recover: errors=%0d issues=%0d, required 2 and 0", err_cnt - e0, issue_cnt - c0);
    end
    exp_q.push_back(8'h45);
    send_char(8'h35);
    wait_drain(60, "err_tail");
  endtask

  task automatic test_overflow();
    int i0;
    do_reset();
    bus.i_tx_busy = 1'b1;
    for (int b = 0; b < 9; b++) send_pair(8'(b), b[0], b < 8);
    @(negedge clk);
    n_vec++;
    if (bus.o_level !== 4'd8 || bus.o_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full: lvl=%0d ovf=%b, required 8 and 1", bus.o_level, bus.o_ovf);
    end
    tick();
    i0 = issue_cyc_q.size();
    bus.i_tx_busy = 1'b0;
    wait_drain(300, "ovf");
    repeat (40) tick();
    check_spacing(i0, 8, "ovf");
    n_vec++;
    if (issue_cyc_q.size() - i0 != 8 || bus.o_ovf !== 1'b1 || bus.o_level !== 4'd0) begin
      n_err++;
      $display("FAIL ovf_drain: issues=%0d ovf=%b lvl=%0d, required 8 1 0",
               issue_cyc_q.size() - i0, bus.o_ovf, bus.o_level);
    end
  endtask

  task automatic test_back_to_back();
    int c0, k;
    do_reset();
    c0 = issue_cnt;
    bus.i_tx_busy = 1'b1;
    for (int b = 8'h10; b < 8'h18; b++) send_pair(8'(b), 1'b0, 1'b1);
    repeat (3) tick();
    send_char(8'h31);
    // second digit strobe and busy release share a cycle: push and pop together
    exp_q.push_back(8'h18);
    bus.i_rx_data  = 8'h38;
    bus.i_rx_valid = 1'b1;
    bus.i_tx_busy  = 1'b0;
    tick();
    bus.i_rx_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.o_level !== 4'd8 || bus.o_ovf !== 1'b0 || bus.o_inst_valid !== 1'b1) begin
      n_err++;
      $display("FAIL full_push_pop: lvl=%0d ovf=%b v=%b, required 8 0 1",
               bus.o_level, bus.o_ovf, bus.o_inst_valid);
    end
    tick();
    for (int b = 8'h19; b < 8'h24; b++) begin
      k = 0;
      while (bus.o_level >= 4'd8 && k < 100) begin
        tick();
        k++;
      end
      send_pair(8'(b), b[1], 1'b1);
    end
    wait_drain(500, "wrap");
    repeat (2) tick();
    n_vec++;
    if (issue_cnt - c0 != 20 || bus.o_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_count: issues=%0d ovf=%b, required 20 and 0", issue_cnt - c0, bus.o_ovf);
    end
  endtask

  task automatic test_mid_reset();
    repeat (20) tick();
    send_char(8'h37);
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({bus.o_inst, bus.o_inst_valid, bus.o_parse_err, bus.o_ovf, bus.o_level} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: inst=%02h v=%b err=%b ovf=%b lvl=%0d, required all 0",
               bus.o_inst, bus.o_inst_valid, bus.o_parse_err, bus.o_ovf, bus.o_level);
    end
    tick();
    send_pair(8'h12, 1'b0, 1'b1);
    wait_drain(60, "midreset");
    repeat (30) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_rx_data  = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_busy  = 1'b0;
    test_reset();
    test_single();
    test_whitespace();
    test_parse_err();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_inst_rx.md
Name: uart_inst_rx

Overview:
- UART-side instruction source. Parses ASCII hex pairs from the UART receiver (`uart_rx_data`/`uart_rx_valid`) into instruction bytes and buffers them in a small FIFO.
- Issues each byte to the sequencer on the same `i_inst`/`i_inst_valid` interface the button stepper drives, paced so the sequencer's UART TX replies are not overrun.
- Lets a host PC script instruction sequences instead of single-stepping with `btnS`.

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW = 8 entries.
- ISSUE_GAP, 16, minimum idle cycles after an issue before the next issue; legal range 1..255.
- INST_W, 8, instruction width driven to the sequencer; the low INST_W bits of each parsed byte are used.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received UART byte (ASCII).
- i_rx_valid  in  1  one-cycle strobe; `i_rx_data` is valid this cycle.
- i_tx_busy  in  1  UART TX busy; while high, no new instruction issues.
- o_inst  out  INST_W  instruction word; valid only while `o_inst_valid` is high.
- o_inst_valid  out  1  one-cycle issue strobe to the sequencer.
- o_parse_err  out  1  one-cycle pulse on a malformed character.
- o_ovf  out  1  sticky FIFO-overflow flag; cleared only by `rst`.
- o_level  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.

Behaviour:
- Reset (sync, active-high):
  - All outputs are 0.
  - FIFO is emptied; parser goes to IDLE; gap counter is 0; any held high nibble is discarded.
  - Reset has priority over every other event in the same cycle.
- Character classes:
  - HEX: 0x30-0x39, 0x41-0x46, 0x61-0x66, mapped to nibble values 0-15.
  - WS: 0x20, 0x0D, 0x0A.
  - BAD: anything else.
- Parser FSM, two states, advances only on cycles with `i_rx_valid` high:
  - IDLE + HEX: store the nibble as the high nibble, go to HI.
  - IDLE + WS: ignored, stay in IDLE.
  - IDLE + BAD: pulse `o_parse_err`, stay in IDLE.
  - HI + HEX: byte = {hi, lo}, request a FIFO push, go to IDLE.
  - HI + WS or BAD: pulse `o_parse_err`, discard the held nibble, go to IDLE.
- `o_parse_err` is registered and asserts the cycle after the offending strobe.
- FIFO (synchronous):
  - A push completes at the edge ending the strobe cycle of the second digit.
  - Push while full with no pop in the same cycle: the byte is dropped, `o_ovf` is set, occupancy is unchanged.
  - Push and pop in the same cycle while full: both occur; nothing is dropped.
  - Push and pop in the same cycle while empty: not possible, since a pop requires a nonempty FIFO at cycle start.
  - `o_level` is registered and reflects the occupancy after each edge.
- Issue logic, evaluated every cycle, all conditions registered:
  - Issue condition: FIFO nonempty, gap counter == 0, `i_tx_busy` == 0, and `o_inst_valid` currently 0.
  - When the condition holds:
    - pop the FIFO head into `o_inst`;
    - assert `o_inst_valid` for exactly the next cycle;
    - load the gap counter with ISSUE_GAP.
  - Gap counter decrements by 1 each cycle while nonzero, saturating at 0.
- Issue timing:
  - Latency from the second-digit strobe in cycle t, FIFO previously empty and idle: `o_inst_valid` is high in cycle t+2.
  - With `i_tx_busy` held low and the FIFO kept nonempty, consecutive `o_inst_valid` rising edges are exactly ISSUE_GAP+1 cycles apart.
  - `i_tx_busy` high stalls issue indefinitely. The gap counter keeps decrementing during the stall; FIFO contents are retained.
- `o_inst` holds its last issued value between strobes.
- Issue order is strict FIFO order; the FIFO pointers wrap modulo 2^FIFO_AW.

Test Plan:
- Send "3A": `o_inst` = 0x3A with a single-cycle `o_inst_valid` 2 cycles after the 'A' strobe; `o_level` returns to 0; `o_parse_err` stays 0.
- Send "fF 0a\r\n": two issues, 0xFF then 0x0A, exactly 17 cycles apart; whitespace causes no error.
- Send "G", then "3 4": `o_parse_err` pulses once for "G" and once for the space; no byte is issued for "3"; the parser recovers to IDLE, and the trailing "4" is held as a high nibble.
- With `i_tx_busy` = 1, send nine pairs 00..08: `o_level` = 8 and `o_ovf` = 1 after the ninth pair. Deassert busy: bytes 00..07 issue in order, 17 cycles apart; 08 never issues; `o_ovf` remains 1.
- FIFO full, with a push and an issue pop landing on the same edge: occupancy stays 8 and `o_ovf` stays 0. Pointer wrap is checked by issuing 20 bytes through the FIFO with order preserved.
- Assert `rst` after a single "7": all outputs are 0 and the FIFO is empty. Then send "12": only 0x12 issues; the pre-reset nibble is never used.
